// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD hh:mm:ss time-of-day counter with a seconds prescaler,
// runtime 12/24-hour display, validated time load and a single armed alarm.
// Time is always held internally in 24-hour BCD. The 12-hour view is derived
// combinationally, so switching display mode never disturbs the count.

module bcd_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  input  logic       alarm_wr,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  input  logic       alarm_arm,
  output logic [3:0] hourst,
  output logic [3:0] hoursu,
  output logic [3:0] mint,
  output logic [3:0] minu,
  output logic [3:0] sect,
  output logic [3:0] secu,
  output logic       pm,
  output logic       min_tick,
  output logic       day_tick,
  output logic       alarm_hit,
  output logic       load_err
);

  // Last prescaler value before it wraps and the second advances.
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  // Hour field check: units 0..9, and 20..23 is the only legal range with tens=2.
  function automatic logic hour_ok(input logic [7:0] h);
    return (h[3:0] <= 4'd9) &&
           ((h[7:4] < 4'd2) || ((h[7:4] == 4'd2) && (h[3:0] <= 4'd3)));
  endfunction

  // Minute/second field check: tens 0..5, units 0..9.
  function automatic logic min_sec_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // 24-hour time digits.
  logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  // Digits the time will take one second from now.
  logic [3:0] hour_t_n, hour_u_n, min_t_n, min_u_n, sec_t_n, sec_u_n;
  // Alarm digits (hh:mm, seconds implicitly 00).
  logic [3:0] al_h_t, al_h_u, al_m_t, al_m_u;

  logic [PRESC_W-1:0] presc;

  logic sec_wrap, min_wrap, hour_wrap;
  logic load_valid, alarm_valid;
  logic load_ok, alarm_ok;
  logic tick, advance;
  logic alarm_match;

  logic [4:0] hour_bin;
  logic [4:0] disp_hour;

  // Strobe qualification; an accepted load suppresses any coincident tick.
  always_comb begin
    load_valid  = hour_ok(load_h) && min_sec_ok(load_m) && min_sec_ok(load_s);
    alarm_valid = hour_ok(alarm_h) && min_sec_ok(alarm_m);
    load_ok     = load && load_valid;
    alarm_ok    = alarm_wr && alarm_valid;
    tick        = en && (presc == PRESC_MAX);
    advance     = tick && !load_ok;
  end

  // One-second increment with BCD carries seconds -> minutes -> hours, 23 wraps to 00.
  always_comb begin
    sec_u_n  = sec_u;
    sec_t_n  = sec_t;
    min_u_n  = min_u;
    min_t_n  = min_t;
    hour_u_n = hour_u;
    hour_t_n = hour_t;

    sec_wrap  = (sec_t == 4'd5) && (sec_u == 4'd9);
    min_wrap  = (min_t == 4'd5) && (min_u == 4'd9);
    hour_wrap = (hour_t == 4'd2) && (hour_u == 4'd3);

    if (sec_u != 4'd9) begin
      sec_u_n = sec_u + 4'd1;
    end else begin
      sec_u_n = 4'd0;
      sec_t_n = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
    end

    if (sec_wrap) begin
      if (min_u != 4'd9) begin
        min_u_n = min_u + 4'd1;
      end else begin
        min_u_n = 4'd0;
        min_t_n = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
      end
    end

    if (sec_wrap && min_wrap) begin
      if (hour_wrap) begin
        hour_t_n = 4'd0;
        hour_u_n = 4'd0;
      end else if (hour_u == 4'd9) begin
        hour_u_n = 4'd0;
        hour_t_n = hour_t + 4'd1;
      end else begin
        hour_u_n = hour_u + 4'd1;
      end
    end

    alarm_match = sec_wrap &&
                  (hour_t_n == al_h_t) && (hour_u_n == al_h_u) &&
                  (min_t_n == al_m_t) && (min_u_n == al_m_u);
  end

  // Prescaler: counts enabled cycles, restarts on an accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load_ok) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PRESC_W'(1);
    end
  end

  // Time registers: load has priority over the one-second advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_t <= 4'd0;
      hour_u <= 4'd0;
      min_t  <= 4'd0;
      min_u  <= 4'd0;
      sec_t  <= 4'd0;
      sec_u  <= 4'd0;
    end else if (load_ok) begin
      hour_t <= load_h[7:4];
      hour_u <= load_h[3:0];
      min_t  <= load_m[7:4];
      min_u  <= load_m[3:0];
      sec_t  <= load_s[7:4];
      sec_u  <= load_s[3:0];
    end else if (advance) begin
      hour_t <= hour_t_n;
      hour_u <= hour_u_n;
      min_t  <= min_t_n;
      min_u  <= min_u_n;
      sec_t  <= sec_t_n;
      sec_u  <= sec_u_n;
    end
  end

  // Alarm registers; a write is compared against from the following tick on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_h_t <= 4'd0;
      al_h_u <= 4'd0;
      al_m_t <= 4'd0;
      al_m_u <= 4'd0;
    end else if (alarm_ok) begin
      al_h_t <= alarm_h[7:4];
      al_h_u <= alarm_h[3:0];
      al_m_t <= alarm_m[7:4];
      al_m_u <= alarm_m[3:0];
    end
  end

  // Registered event pulses, visible together with the new time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_tick  <= advance && sec_wrap;
      day_tick  <= advance && sec_wrap && min_wrap && hour_wrap;
      alarm_hit <= advance && alarm_arm && alarm_match;
      load_err  <= (load && !load_valid) || (alarm_wr && !alarm_valid);
    end
  end

  // Display hour: 24-hour digits pass through, 12-hour maps 0->12 and 13..23->1..11.
  always_comb begin
    hour_bin  = 5'(hour_t) * 5'd10 + 5'(hour_u);
    pm        = (hour_bin >= 5'd12);
    disp_hour = hour_bin;
    hourst    = hour_t;
    hoursu    = hour_u;
    if (mode_12h) begin
      if (hour_bin == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_hour = hour_bin - 5'd12;
      end
      if (disp_hour >= 5'd10) begin
        hourst = 4'd1;
        hoursu = 4'(disp_hour - 5'd10);
      end else begin
        hourst = 4'd0;
        hoursu = 4'(disp_hour);
      end
    end
  end

  assign mint = min_t;
  assign minu = min_u;
  assign sect = sec_t;
  assign secu = sec_u;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed vector table plus hand-written reset sequences
// for bcd_time_counter, run with four enabled cycles per second.

module tb_bcd_time_counter;

  localparam int unsigned TPS = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode_12h;
  logic       load;
  logic [7:0] load_h, load_m, load_s;
  logic       alarm_wr;
  logic [7:0] alarm_h, alarm_m;
  logic       alarm_arm;
  logic [3:0] hourst, hoursu, mint, minu, sect, secu;
  logic       pm, min_tick, day_tick, alarm_hit, load_err;

  int total = 0;
  int bad   = 0;

  bcd_time_counter #(
    .TICKS_PER_SEC(TPS),
    .PRESC_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode_12h(mode_12h),
    .load(load),
    .load_h(load_h),
    .load_m(load_m),
    .load_s(load_s),
    .alarm_wr(alarm_wr),
    .alarm_h(alarm_h),
    .alarm_m(alarm_m),
    .alarm_arm(alarm_arm),
    .hourst(hourst),
    .hoursu(hoursu),
    .mint(mint),
    .minu(minu),
    .sect(sect),
    .secu(secu),
    .pm(pm),
    .min_tick(min_tick),
    .day_tick(day_tick),
    .alarm_hit(alarm_hit),
    .load_err(load_err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One strobe cycle with the given inputs, then 'cycles' further edges with
  // en/mode/arm held; expectations are checked after the last edge.
  typedef struct {
    string       name;
    logic        ld;
    logic [23:0] lt;
    logic        aw;
    logic [15:0] at;
    logic        arm;
    logic        en;
    logic        mode;
    int          cycles;
    logic [23:0] et;
    logic        epm;
    logic [2:0]  ep;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic ld, input logic [23:0] lt,
                              input logic aw, input logic [15:0] at, input logic arm,
                              input logic en_v, input logic mode, input int cycles,
                              input logic [23:0] et, input logic epm, input logic [2:0] ep,
                              input logic eerr);
    vec_t v;
    v.name = name; v.ld = ld; v.lt = lt; v.aw = aw; v.at = at; v.arm = arm;
    v.en = en_v; v.mode = mode; v.cycles = cycles;
    v.et = et; v.epm = epm; v.ep = ep; v.eerr = eerr;
    return v;
  endfunction

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [23:0] et, input logic epm,
                             input logic [2:0] ep, input logic eerr);
    compareField({name, ".time"}, 32'({hourst, hoursu, mint, minu, sect, secu}), 32'(et));
    compareField({name, ".pm"}, 32'(pm), 32'(epm));
    compareField({name, ".pulses"}, 32'({min_tick, day_tick, alarm_hit}), 32'(ep));
    compareField({name, ".load_err"}, 32'(load_err), 32'(eerr));
  endtask

  task automatic applyStimulus(input vec_t v);
    load      = v.ld;
    {load_h, load_m, load_s} = v.lt;
    alarm_wr  = v.aw;
    {alarm_h, alarm_m} = v.at;
    alarm_arm = v.arm;
    en        = v.en;
    mode_12h  = v.mode;
    @(posedge clk);
    #1;
    load     = 1'b0;
    alarm_wr = 1'b0;
    repeat (v.cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v);
    checkOutput(v.name, v.et, v.epm, v.ep, v.eerr);
  endtask

  // Main sequence: reset checks, vector table, then asynchronous reset cases.
  initial begin
    rst_n = 1'b0; en = 1'b0; mode_12h = 1'b0; load = 1'b0;
    load_h = 8'h00; load_m = 8'h00; load_s = 8'h00;
    alarm_wr = 1'b0; alarm_h = 8'h00; alarm_m = 8'h00; alarm_arm = 1'b0;

    //        name              ld lt         aw at       arm en md cyc expected   pm pulses err
    vecs.push_back(mk("count40",       0, 24'h000000, 0, 16'h0000, 0, 1, 0, 39, 24'h000010, 0, 3'b000, 0));
    vecs.push_back(mk("ld_235958",     1, 24'h235958, 0, 16'h0000, 0, 1, 0, 0,  24'h235958, 1, 3'b000, 0));
    vecs.push_back(mk("tick_235959",   0, 24'h000000, 0, 16'h0000, 0, 1, 0, 3,  24'h235959, 1, 3'b000, 0));
    vecs.push_back(mk("day_wrap",      0, 24'h000000, 0, 16'h0000, 0, 1, 0, 3,  24'h000000, 0, 3'b110, 0));
    vecs.push_back(mk("wrap_drop",     0, 24'h000000, 0, 16'h0000, 0, 0, 0, 0,  24'h000000, 0, 3'b000, 0));
    vecs.push_back(mk("ld_1305_12h",   1, 24'h130500, 0, 16'h0000, 0, 0, 1, 0,  24'h010500, 1, 3'b000, 0));
    vecs.push_back(mk("show_1305_24h", 0, 24'h000000, 0, 16'h0000, 0, 0, 0, 0,  24'h130500, 1, 3'b000, 0));
    vecs.push_back(mk("ld_0030_12h",   1, 24'h003000, 0, 16'h0000, 0, 0, 1, 0,  24'h123000, 0, 3'b000, 0));
    vecs.push_back(mk("ld_1200_12h",   1, 24'h120000, 0, 16'h0000, 0, 0, 1, 0,  24'h120000, 1, 3'b000, 0));
    vecs.push_back(mk("ld_0100_12h",   1, 24'h010000, 0, 16'h0000, 0, 0, 1, 0,  24'h010000, 0, 3'b000, 0));
    vecs.push_back(mk("ld_2300_12h",   1, 24'h230000, 0, 16'h0000, 0, 0, 1, 0,  24'h110000, 1, 3'b000, 0));
    vecs.push_back(mk("bad_h24",       1, 24'h240000, 0, 16'h0000, 0, 0, 0, 0,  24'h230000, 1, 3'b000, 1));
    vecs.push_back(mk("bad_m60",       1, 24'h126000, 0, 16'h0000, 0, 0, 0, 0,  24'h230000, 1, 3'b000, 1));
    vecs.push_back(mk("bad_s0A",       1, 24'h12000A, 0, 16'h0000, 0, 0, 0, 0,  24'h230000, 1, 3'b000, 1));
    vecs.push_back(mk("bad_hu",        1, 24'h1A0000, 0, 16'h0000, 0, 0, 0, 0,  24'h230000, 1, 3'b000, 1));
    vecs.push_back(mk("err_drop",      0, 24'h000000, 0, 16'h0000, 0, 0, 0, 0,  24'h230000, 1, 3'b000, 0));
    vecs.push_back(mk("ld_195959",     1, 24'h195959, 0, 16'h0000, 0, 0, 0, 0,  24'h195959, 1, 3'b000, 0));
    vecs.push_back(mk("alarm_set",     1, 24'h065959, 1, 16'h0700, 1, 0, 0, 0,  24'h065959, 0, 3'b000, 0));
    vecs.push_back(mk("alarm_hit",     0, 24'h000000, 0, 16'h0000, 1, 1, 0, 3,  24'h070000, 0, 3'b101, 0));
    vecs.push_back(mk("alarm_drop",    0, 24'h000000, 0, 16'h0000, 1, 0, 0, 0,  24'h070000, 0, 3'b000, 0));
    vecs.push_back(mk("ld_unarmed",    1, 24'h065959, 0, 16'h0000, 0, 0, 0, 0,  24'h065959, 0, 3'b000, 0));
    vecs.push_back(mk("no_hit_unarm",  0, 24'h000000, 0, 16'h0000, 0, 1, 0, 3,  24'h070000, 0, 3'b100, 0));
    vecs.push_back(mk("ld_0700_direct",1, 24'h070000, 0, 16'h0000, 1, 0, 0, 0,  24'h070000, 0, 3'b000, 0));
    vecs.push_back(mk("after_direct",  0, 24'h000000, 0, 16'h0000, 1, 1, 0, 3,  24'h070001, 0, 3'b000, 0));
    vecs.push_back(mk("bad_alarm_h",   0, 24'h000000, 1, 16'h2500, 1, 0, 0, 0,  24'h070001, 0, 3'b000, 1));
    vecs.push_back(mk("ld_bad_alarm_m",1, 24'h100000, 1, 16'h0861, 1, 0, 0, 0,  24'h100000, 0, 3'b000, 1));
    vecs.push_back(mk("rearm_0659",    1, 24'h065959, 0, 16'h0000, 1, 0, 0, 0,  24'h065959, 0, 3'b000, 0));
    vecs.push_back(mk("alarm_kept",    0, 24'h000000, 0, 16'h0000, 1, 1, 0, 3,  24'h070000, 0, 3'b101, 0));
    vecs.push_back(mk("ld_0500",       1, 24'h050000, 0, 16'h0000, 0, 1, 0, 0,  24'h050000, 0, 3'b000, 0));
    vecs.push_back(mk("presc_to_max",  0, 24'h000000, 0, 16'h0000, 0, 1, 0, 2,  24'h050000, 0, 3'b000, 0));
    vecs.push_back(mk("ld_on_tick",    1, 24'h080808, 0, 16'h0000, 0, 1, 0, 0,  24'h080808, 0, 3'b000, 0));
    vecs.push_back(mk("hold_after_ld", 0, 24'h000000, 0, 16'h0000, 0, 1, 0, 2,  24'h080808, 0, 3'b000, 0));
    vecs.push_back(mk("first_tick",    0, 24'h000000, 0, 16'h0000, 0, 1, 0, 0,  24'h080809, 0, 3'b000, 0));

    // Reset values in both display modes while reset is held.
    #12;
    checkOutput("reset_24h", 24'h000000, 1'b0, 3'b000, 1'b0);
    mode_12h = 1'b1;
    #1;
    checkOutput("reset_12h", 24'h120000, 1'b0, 3'b000, 1'b0);
    mode_12h = 1'b0;
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i]);
    end

    // Reset while min_tick is high: pulse and time clear immediately.
    runVector(mk("ld_123459", 1, 24'h123459, 0, 16'h0000, 0, 1, 0, 0, 24'h123459, 1, 3'b000, 0));
    runVector(mk("min_before_rst", 0, 24'h000000, 0, 16'h0000, 0, 1, 0, 3, 24'h123500, 1, 3'b100, 0));
    rst_n = 1'b0;
    #2;
    checkOutput("rst_pulse_drop", 24'h000000, 1'b0, 3'b000, 1'b0);
    rst_n = 1'b1;

    // Reset at 12:34:56 with the prescaler part-way: it must restart from zero.
    runVector(mk("ld_123456", 1, 24'h123456, 0, 16'h0000, 0, 1, 0, 0, 24'h123456, 1, 3'b000, 0));
    runVector(mk("presc_mid", 0, 24'h000000, 0, 16'h0000, 0, 1, 0, 1, 24'h123456, 1, 3'b000, 0));
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_count", 24'h000000, 1'b0, 3'b000, 1'b0);
    rst_n = 1'b1;
    runVector(mk("post_rst_hold", 0, 24'h000000, 0, 16'h0000, 0, 1, 0, 2, 24'h000000, 0, 3'b000, 0));
    runVector(mk("post_rst_tick", 0, 24'h000000, 0, 16'h0000, 0, 1, 0, 0, 24'h000001, 0, 3'b000, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
